// File: rtl/mem_bus_sram_slave.sv
// rtl/mem_bus_sram_slave.sv - word-organised SRAM responder for the processor memory bus
// Accepts one read or write at a time, commits it after LATENCY wait states and pulses ready for one cycle.
module mem_bus_sram_slave #(
    parameter int    ADDR_W    = 15,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:2] addr,
    input  logic [31:0] dataD,
    output logic [31:0] dataQ,
    input  logic        read,
    input  logic        write,
    output logic        ready,
    input  logic [3:0]  byteSel
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [3:0]        be_q;
    logic              wr_q;
    logic [31:0]       dataQ_q;

    logic [31:0]       mem [2**ADDR_W];

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] op_addr;
    logic [31:0]       op_data;
    logic [3:0]        op_be;
    logic              op_wr;

    generate
        if (ADDR_W < 15) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[16:ADDR_W+2];
        end
    endgenerate

    // With LATENCY=0 the access commits on the accepting edge, so live inputs feed the commit path while IDLE.
    always_comb begin
        accept  = (state_q == IDLE) && (read || write);
        op_addr = addr_q;
        op_data = data_q;
        op_be   = be_q;
        op_wr   = wr_q;
        if (state_q == IDLE) begin
            op_addr = addr[ADDR_W+1:2];
            op_data = dataD;
            op_be   = byteSel;
            op_wr   = write;
        end

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LATENCY > 0) begin
                        state_d = WAIT;
                        cnt_d   = 4'(LATENCY - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        commit = (state_d == RESP) && (state_q != RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            data_q  <= 32'h0;
            be_q    <= 4'h0;
            wr_q    <= 1'b0;
            dataQ_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q <= addr[ADDR_W+1:2];
                data_q <= dataD;
                be_q   <= byteSel;
                wr_q   <= write;
            end
            if (commit && !op_wr) begin
                dataQ_q <= mem[op_addr];
            end
        end
    end

    // The array is never reset; rst only blocks a commit that would coincide with it.
    always_ff @(posedge clk) begin
        if (commit && op_wr && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (op_be[i]) begin
                    mem[op_addr][8*i +: 8] <= op_data[8*i +: 8];
                end
            end
        end
    end

    assign ready = (state_q == RESP);
    assign dataQ = dataQ_q;

endmodule
